lc3b_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the LC-3b pipeline. It generalises the fixed two-source forward encoding (none / ex_ex / mem_ex) to an arbitrary number of post-decode stages and a configurable load latency. It tracks in-flight destination registers in an internal shift scoreboard, drives per-source forward selects and a decode stall, and keeps a saturating stall-cycle counter. It sits beside decode and feeds the EX-stage operand muxes.

---
 rtl/lc3b_hazard_unit.sv | 123 ++++++++++++
 tb/tb_lc3b_hazard_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_hazard_unit.sv
// lc3b_hazard_unit
//   Forwarding and load-use hazard unit for the LC-3b pipeline. A shift
//   scoreboard records, for every post-decode stage 1..STAGES, whether the
//   stage holds a valid instruction, its destination register, whether that
//   instruction writes the register, and whether it is a load.
//   For each decode source the youngest in-flight writer of that register is
//   located. If its result already exists, the source is forwarded from that
//   stage. If it does not yet exist (a load still too close to EX), decode is
//   stalled and a bubble is inserted.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   id_valid                  decode holds a valid instruction
//   id_sr1 / id_sr1_used      source 1 index and read enable
//   id_sr2 / id_sr2_used      source 2 index and read enable
//   id_dr / id_wr             destination index and write enable
//   id_is_load                instruction is LDR/LDB/LDI
//   pipe_hold                 downstream freeze; the scoreboard does not move
//   flush                     squash decode and stage 1
//   fwd_sel1 / fwd_sel2       0 = regfile, k = result of stage k
//   stall                     hold fetch/decode and insert a bubble
//   stall_cnt                 saturating count of stall cycles
module lc3b_hazard_unit #(
  parameter int STAGES   = 2,
  parameter int LOAD_LAT = 1,
  parameter int REG_W    = 3,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_sr1,
  input  logic             id_sr1_used,
  input  logic [REG_W-1:0] id_sr2,
  input  logic             id_sr2_used,
  input  logic [REG_W-1:0] id_dr,
  input  logic             id_wr,
  input  logic             id_is_load,
  input  logic             pipe_hold,
  input  logic             flush,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  // Scoreboard: index k is pipeline stage k (1 = EX).
  logic [STAGES:1] sb_v;
  logic [STAGES:1] sb_wr;
  logic [STAGES:1] sb_ld;
  logic [REG_W-1:0] sb_dr [1:STAGES];

  logic hazard1;
  logic hazard2;

  // Handshake: decode presents an instruction with id_valid; it is accepted
  // into stage 1 on a clock edge where id_valid && !stall && !flush &&
  // !pipe_hold. While stall is high, decode must hold the same instruction.

  // Source lookup. Stages are scanned from oldest to youngest so that the
  // youngest match overwrites any older one. An unready youngest match
  // clears the select, so an older (stale) value is never forwarded.
  always_comb begin
    fwd_sel1 = '0;
    hazard1  = 1'b0;
    fwd_sel2 = '0;
    hazard2  = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (id_valid && id_sr1_used && sb_v[k] && sb_wr[k] && (sb_dr[k] == id_sr1)) begin
        if (!sb_ld[k] || (k > LOAD_LAT)) begin
          fwd_sel1 = SEL_W'(k);
          hazard1  = 1'b0;
        end else begin
          fwd_sel1 = '0;
          hazard1  = 1'b1;
        end
      end
      if (id_valid && id_sr2_used && sb_v[k] && sb_wr[k] && (sb_dr[k] == id_sr2)) begin
        if (!sb_ld[k] || (k > LOAD_LAT)) begin
          fwd_sel2 = SEL_W'(k);
          hazard2  = 1'b0;
        end else begin
          fwd_sel2 = '0;
          hazard2  = 1'b1;
        end
      end
    end
  end

  // A flushed instruction in decode is discarded anyway, so it cannot stall.
  assign stall = (hazard1 || hazard2) && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_v      <= '0;
      sb_wr     <= '0;
      sb_ld     <= '0;
      stall_cnt <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        sb_dr[k] <= '0;
      end
    end else if (!pipe_hold) begin
      // Shift older stages; on flush the instruction leaving stage 1 was on
      // the wrong path and is dropped rather than moved into stage 2.
      for (int k = STAGES; k >= 2; k--) begin
        sb_v[k]  <= sb_v[k-1] && !(flush && (k == 2));
        sb_wr[k] <= sb_wr[k-1];
        sb_ld[k] <= sb_ld[k-1];
        sb_dr[k] <= sb_dr[k-1];
      end
      sb_v[1]  <= id_valid && !stall && !flush;
      sb_wr[1] <= id_wr;
      sb_ld[1] <= id_is_load;
      sb_dr[1] <= id_dr;

      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lc3b_hazard_unit.sv
// tb_lc3b_hazard_unit
//   Directed bench for lc3b_hazard_unit (STAGES=2, LOAD_LAT=1). Two instances
//   share the stimulus: dut_a with a 16-bit stall counter and dut_b with a
//   4-bit one, which exercises saturation. A queue of in-flight instructions,
//   each tagged with its current stage, predicts the outputs every cycle;
//   hand-computed literals pin that prediction at key points.
module tb_lc3b_hazard_unit;

  localparam int STAGES   = 2;
  localparam int LOAD_LAT = 1;
  localparam int SEL_W    = $clog2(STAGES + 1);

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid = 1'b0;
  logic [2:0] id_sr1 = '0;
  logic       id_sr1_used = 1'b0;
  logic [2:0] id_sr2 = '0;
  logic       id_sr2_used = 1'b0;
  logic [2:0] id_dr = '0;
  logic       id_wr = 1'b0;
  logic       id_is_load = 1'b0;
  logic       pipe_hold = 1'b0;
  logic       flush = 1'b0;

  logic [SEL_W-1:0] sel1_a, sel2_a, sel1_b, sel2_b;
  logic             stall_a, stall_b;
  logic [15:0]      cnt_a;
  logic [3:0]       cnt_b;

  lc3b_hazard_unit #(.STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .REG_W(3), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_sr1(id_sr1), .id_sr1_used(id_sr1_used), .id_sr2(id_sr2), .id_sr2_used(id_sr2_used),
    .id_dr(id_dr), .id_wr(id_wr), .id_is_load(id_is_load),
    .pipe_hold(pipe_hold), .flush(flush),
    .fwd_sel1(sel1_a), .fwd_sel2(sel2_a), .stall(stall_a), .stall_cnt(cnt_a)
  );

  lc3b_hazard_unit #(.STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .REG_W(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_sr1(id_sr1), .id_sr1_used(id_sr1_used), .id_sr2(id_sr2), .id_sr2_used(id_sr2_used),
    .id_dr(id_dr), .id_wr(id_wr), .id_is_load(id_is_load),
    .pipe_hold(pipe_hold), .flush(flush),
    .fwd_sel1(sel1_b), .fwd_sel2(sel2_b), .stall(stall_b), .stall_cnt(cnt_b)
  );

  // model: list of in-flight writers, each with the stage it occupies
  typedef struct {
    logic [2:0] dr;
    logic       wr;
    logic       ld;
    int         stage;
  } inst_t;

  inst_t flight[$];
  int    mcnt_a = 0;
  int    mcnt_b = 0;

  function automatic void m_pick(input logic [2:0] src, input logic used,
                                 output int sel, output bit haz);
    int   best;
    logic best_ld;
    best    = STAGES + 1;
    best_ld = 1'b0;
    foreach (flight[i]) begin
      if (flight[i].wr && flight[i].dr == src && flight[i].stage < best) begin
        best    = flight[i].stage;
        best_ld = flight[i].ld;
      end
    end
    sel = 0;
    haz = 1'b0;
    if (id_valid && used && best <= STAGES) begin
      if (!best_ld || best > LOAD_LAT) sel = best;
      else haz = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    int    s1, s2;
    bit    h1, h2, st;
    inst_t nq[$];
    inst_t e;
    if (!reset_n) begin
      flight.delete();
      mcnt_a = 0;
      mcnt_b = 0;
    end else if (!pipe_hold) begin
      m_pick(id_sr1, id_sr1_used, s1, h1);
      m_pick(id_sr2, id_sr2_used, s2, h2);
      st = (h1 || h2) && !flush;
      if (st) begin
        mcnt_a = mcnt_a + 1;
        if (mcnt_b < 15) mcnt_b = mcnt_b + 1;
      end
      nq.delete();
      foreach (flight[i]) begin
        e = flight[i];
        if (!(flush && e.stage == 1)) begin
          e.stage = e.stage + 1;
          if (e.stage <= STAGES) nq.push_back(e);
        end
      end
      if (id_valid && !st && !flush) begin
        e.dr = id_dr; e.wr = id_wr; e.ld = id_is_load; e.stage = 1;
        nq.push_back(e);
      end
      flight = nq;
    end
  end

  // literal expectations posted by the driver for the current cycle
  logic lit_en = 1'b0;
  int   lit_sel1 = 0, lit_sel2 = 0, lit_stall = 0, lit_cnt = 0, lit_cnt4 = 0;

  // scoreboard
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every negedge, and right after an asynchronous reset
  initial begin
    int  s1, s2, est;
    bit  h1, h2;
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      if (!reset_n) begin
        chk("reset_sel1_a", int'(sel1_a), 0);
        chk("reset_sel2_a", int'(sel2_a), 0);
        chk("reset_stall_a", int'(stall_a), 0);
        chk("reset_cnt_a", int'(cnt_a), 0);
        chk("reset_stall_b", int'(stall_b), 0);
        chk("reset_cnt_b", int'(cnt_b), 0);
      end else begin
        m_pick(id_sr1, id_sr1_used, s1, h1);
        m_pick(id_sr2, id_sr2_used, s2, h2);
        est = ((h1 || h2) && !flush) ? 1 : 0;
        chk("model_sel1_a", int'(sel1_a), s1);
        chk("model_sel2_a", int'(sel2_a), s2);
        chk("model_stall_a", int'(stall_a), est);
        chk("model_cnt_a", int'(cnt_a), mcnt_a);
        chk("model_sel1_b", int'(sel1_b), s1);
        chk("model_sel2_b", int'(sel2_b), s2);
        chk("model_stall_b", int'(stall_b), est);
        chk("model_cnt_b", int'(cnt_b), mcnt_b);
        if (lit_en) begin
          chk("lit_sel1", int'(sel1_a), lit_sel1);
          chk("lit_sel2", int'(sel2_a), lit_sel2);
          chk("lit_stall", int'(stall_a), lit_stall);
          chk("lit_cnt_a", int'(cnt_a), lit_cnt);
          chk("lit_cnt_b", int'(cnt_b), lit_cnt4);
        end
      end
    end
  end

  // driver tasks
  task automatic set_in(input logic v, input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2, input logic [2:0] dr,
                        input logic wr, input logic ld, input logic hold, input logic fl);
    id_valid = v; id_sr1 = s1; id_sr1_used = u1; id_sr2 = s2; id_sr2_used = u2;
    id_dr = dr; id_wr = wr; id_is_load = ld; pipe_hold = hold; flush = fl;
  endtask

  task automatic post_lit(input logic en, input int e1, input int e2, input int es, input int ec);
    lit_en = en; lit_sel1 = e1; lit_sel2 = e2; lit_stall = es; lit_cnt = ec;
    lit_cnt4 = (ec > 15) ? 15 : ec;
  endtask

  task automatic step(input logic v, input logic [2:0] s1, input logic u1,
                      input logic [2:0] s2, input logic u2, input logic [2:0] dr,
                      input logic wr, input logic ld, input logic hold, input logic fl,
                      input logic en, input int e1, input int e2, input int es, input int ec);
    set_in(v, s1, u1, s2, u2, dr, wr, ld, hold, fl);
    post_lit(en, e1, e2, es, ec);
    @(posedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  initial begin
    // reset held for two edges
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    //   v sr1 u  sr2 u  dr wr ld hold fl  lit sel1 sel2 stall cnt
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);   // ADD R1
    step(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 1, 1, 1, 0, 0);   // ADD R2,R1,R1
    step(1, 6, 1, 0, 0, 2, 1, 1, 0, 0, 1, 0, 0, 0, 0);   // LDR R2,[R6]
    step(1, 2, 1, 4, 1, 3, 1, 0, 0, 0, 1, 0, 0, 1, 0);   // ADD R3,R2,R4 load-use
    step(1, 2, 1, 4, 1, 3, 1, 0, 0, 0, 1, 2, 0, 0, 1);   // retried, load in stage 2
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0, 1);   // ADD R4
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0, 1);   // ADD R4
    step(1, 4, 1, 0, 0, 4, 1, 1, 0, 0, 1, 1, 0, 0, 1);   // LDR R4,[R4]: youngest wins
    step(1, 4, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 0, 1, 1);   // ADD R6,R4: unready youngest
    step(1, 4, 1, 0, 0, 6, 1, 0, 0, 0, 1, 2, 0, 0, 2);
    step(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, 0, 2);   // LDR R5,[R0]
    for (int i = 0; i < 3; i++)
      step(1, 5, 1, 0, 0, 7, 1, 0, 1, 0, 1, 0, 0, 1, 2); // hold: frozen, no count
    step(1, 5, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0, 0, 1, 2);   // released: one stall
    step(1, 5, 1, 0, 0, 7, 1, 0, 0, 0, 1, 2, 0, 0, 3);
    step(1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 1, 0, 0, 0, 3);   // LDR R5,[R0]
    step(1, 5, 1, 0, 0, 3, 1, 0, 0, 1, 1, 0, 0, 0, 3);   // consumer under flush
    step(1, 5, 1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);   // stages 1,2 now empty

    // LDR R1,[R1] repeated: a load-use stall every other cycle, 20 in all
    for (int i = 0; i < 40; i++)
      step(1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 2, 0, 0, 23);  // dut_b saturated at 15

    // stalled cycle, then reset pulsed mid-cycle across a clock edge
    set_in(1, 1, 1, 0, 0, 1, 1, 1, 0, 0);
    post_lit(1, 0, 0, 1, 23);
    @(negedge clk);
    #3;
    lit_en  = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0);   // first cycle after release
    step(1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
